// File: rtl/keypad_scan.sv
// keypad_scan: scanned 4x4 matrix-keypad reader for the stopwatch front panel.
// Rotates an active-low column strobe on the 200 Hz scan clock, gathers one
// frame of active-low row samples, debounces whole-frame results and shifts
// each accepted key code into a 4-digit register that feeds the display.

module keypad_scan #(
   parameter int DEBOUNCE = 3
) (
   input  logic        clk_200Hz,
   input  logic        rst,
   input  logic        EN,
   input  logic [3:0]  kp_row,
   output logic [3:0]  kp_col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] digits
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2
   } state_t;

   localparam logic [3:0] DB = DEBOUNCE[3:0];

   // Scan state
   logic [3:0]  col_r;
   logic [1:0]  idx_r;
   logic [11:0] acc_r;      // row-low bits of columns 0..2, column c at [4c+3:4c]

   // Debounce / output state
   state_t      state_r;
   logic [3:0]  cand_r;
   logic [3:0]  cnt_r;
   logic [3:0]  rcnt_r;
   logic [3:0]  key_code_r;
   logic        key_valid_r;
   logic        key_held_r;
   logic [15:0] digits_r;

   // Frame decode
   logic [15:0] frame_low_s;
   logic        frame_end_s;
   logic        frame_single_s;
   logic [3:0]  frame_code_s;

   // Classify a frame: exactly one low bit gives SINGLE with code 4*r + c.
   // Bit index i of the frame vector is 4*c + r, so the code is {r, c}.
   function automatic logic [4:0] decode_frame(input logic [15:0] low);
      logic [4:0] hits;
      logic [3:0] pos;
      hits = 5'd0;
      pos  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         hits = hits + {4'd0, low[i]};
         pos  = low[i] ? i[3:0] : pos;
      end
      return {(hits == 5'd1), pos[1:0], pos[3:2]};
   endfunction

   // Combine the stored samples with the live column-3 sample and classify.
   always_comb begin
      frame_low_s = {~kp_row, acc_r};
      frame_end_s = (idx_r == 2'd3);
      {frame_single_s, frame_code_s} = decode_frame(frame_low_s);
   end

   // Column strobe rotation and per-column row sampling.
   always_ff @(posedge clk_200Hz) begin
      if (rst) begin
         col_r <= 4'b1110;
         idx_r <= 2'd0;
         acc_r <= 12'd0;
      end else if (!EN) begin
         // Park on column 0 so it is strobed as soon as EN returns.
         col_r <= 4'b1110;
         idx_r <= 2'd0;
         acc_r <= 12'd0;
      end else begin
         col_r <= {col_r[2:0], col_r[3]};
         idx_r <= idx_r + 2'd1;
         case (idx_r)
            2'd0:    acc_r[3:0]  <= ~kp_row;
            2'd1:    acc_r[7:4]  <= ~kp_row;
            2'd2:    acc_r[11:8] <= ~kp_row;
            default: acc_r       <= acc_r;   // column 3 is consumed live
         endcase
      end
   end

   // Frame-level debounce FSM with accept/release actions.
   always_ff @(posedge clk_200Hz) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cand_r      <= 4'd0;
         cnt_r       <= 4'd0;
         rcnt_r      <= 4'd0;
         key_code_r  <= 4'd0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
         digits_r    <= 16'd0;
      end else if (!EN) begin
         // Scanning stopped: drop any debounce in progress, keep the digits.
         state_r     <= S_IDLE;
         cand_r      <= 4'd0;
         cnt_r       <= 4'd0;
         rcnt_r      <= 4'd0;
         key_valid_r <= 1'b0;
         key_held_r  <= 1'b0;
      end else begin
         key_valid_r <= 1'b0;
         if (frame_end_s) begin
            case (state_r)
               S_IDLE: begin
                  if (frame_single_s) begin
                     if (DB == 4'd1) begin
                        key_code_r  <= frame_code_s;
                        digits_r    <= {digits_r[11:0], frame_code_s};
                        key_valid_r <= 1'b1;
                        key_held_r  <= 1'b1;
                        cand_r      <= frame_code_s;
                        cnt_r       <= 4'd0;
                        rcnt_r      <= 4'd0;
                        state_r     <= S_PRESSED;
                     end else begin
                        cand_r  <= frame_code_s;
                        cnt_r   <= 4'd1;
                        state_r <= S_DEBOUNCE;
                     end
                  end else begin
                     cnt_r <= 4'd0;
                  end
               end
               S_DEBOUNCE: begin
                  if (frame_single_s && (frame_code_s == cand_r)) begin
                     if ((cnt_r + 4'd1) == DB) begin
                        key_code_r  <= cand_r;
                        digits_r    <= {digits_r[11:0], cand_r};
                        key_valid_r <= 1'b1;
                        key_held_r  <= 1'b1;
                        cnt_r       <= 4'd0;
                        rcnt_r      <= 4'd0;
                        state_r     <= S_PRESSED;
                     end else begin
                        cnt_r <= cnt_r + 4'd1;
                     end
                  end else if (frame_single_s) begin
                     // A different single key restarts the count on it.
                     cand_r <= frame_code_s;
                     cnt_r  <= 4'd1;
                  end else begin
                     // NONE and MULTI both abandon the candidate.
                     cnt_r   <= 4'd0;
                     state_r <= S_IDLE;
                  end
               end
               S_PRESSED: begin
                  if (frame_single_s && (frame_code_s == key_code_r)) begin
                     rcnt_r <= 4'd0;
                  end else if ((rcnt_r + 4'd1) == DB) begin
                     rcnt_r     <= 4'd0;
                     key_held_r <= 1'b0;
                     state_r    <= S_IDLE;
                  end else begin
                     rcnt_r <= rcnt_r + 4'd1;
                  end
               end
               default: begin
                  state_r    <= S_IDLE;
                  cnt_r      <= 4'd0;
                  rcnt_r     <= 4'd0;
                  key_held_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // While stopped, no column is strobed; otherwise show the rotating strobe.
   assign kp_col    = EN ? col_r : 4'b1111;
   assign key_code  = key_code_r;
   assign key_valid = key_valid_r;
   assign key_held  = key_held_r;
   assign digits    = digits_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a behavioural 4x4 keypad.
// A pressed key (r, c) pulls row r low whenever column c is strobed low.

module tb_keypad_scan;

   logic        clk_200Hz = 1'b0;
   logic        rst;
   logic        EN;
   logic [3:0]  kp_row;
   logic [3:0]  kp_col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] digits;

   logic [15:0] keys;       // bit 4*r + c set = key (r, c) pressed
   int n_checks = 0;
   int n_pass   = 0;

   keypad_scan #(.DEBOUNCE(3)) dut (
      .clk_200Hz (clk_200Hz),
      .rst       (rst),
      .EN        (EN),
      .kp_row    (kp_row),
      .kp_col    (kp_col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .digits    (digits)
   );

   always #5 clk_200Hz = ~clk_200Hz;

   // Keypad matrix model with pull-ups on the rows.
   always_comb begin
      kp_row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
   end

   task automatic tick;
      @(posedge clk_200Hz);
      #1;
   endtask

   // Apply reset; the next rising edge after return is edge 1.
   task automatic do_reset;
      rst  = 1'b1;
      EN   = 1'b1;
      keys = 16'd0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // Run n edges, counting key_valid pulses and the first edge one appeared.
   task automatic run_count(input int n, output int pulses, output int first);
      pulses = 0;
      first  = 0;
      for (int t = 1; t <= n; t++) begin
         tick;
         if (key_valid) begin
            pulses++;
            if (first == 0) first = t;
         end
      end
   endtask

   task automatic test_reset;
      do_reset;
      n_checks++; if (kp_col !== 4'b1110) $display("FAIL reset_kp_col: got %b want 1110", kp_col); else n_pass++;
      n_checks++; if (key_code !== 4'd0) $display("FAIL reset_key_code: got %0d want 0", key_code); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid); else n_pass++;
      n_checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b want 0", key_held); else n_pass++;
      n_checks++; if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits); else n_pass++;
   endtask

   task automatic test_press_latency;
      int early;
      do_reset;
      keys  = 16'h0020;     // key 5: row 1, column 1
      early = 0;
      for (int t = 1; t <= 13; t++) begin
         tick;
         if (t < 12 && key_valid) early++;
         if (t == 4) begin
            n_checks++; if (kp_col !== 4'b1110) $display("FAIL scan_rotation: got %b want 1110 after 4 edges", kp_col); else n_pass++;
         end
         if (t == 12) begin
            n_checks++; if (key_valid !== 1'b1) $display("FAIL press_valid: got %b want 1 after edge 12", key_valid); else n_pass++;
            n_checks++; if (key_code !== 4'd5) $display("FAIL press_code: got %0d want 5", key_code); else n_pass++;
            n_checks++; if (digits !== 16'h0005) $display("FAIL press_digits: got %h want 0005", digits); else n_pass++;
            n_checks++; if (key_held !== 1'b1) $display("FAIL press_held: got %b want 1", key_held); else n_pass++;
         end
      end
      n_checks++; if (early !== 0) $display("FAIL press_early: got %0d early pulses want 0", early); else n_pass++;
      n_checks++; if (key_valid !== 1'b0) $display("FAIL press_one_cycle: got %b want 0 after edge 13", key_valid); else n_pass++;
   endtask

   task automatic test_bounce_press;
      int p, f;
      do_reset;
      keys = 16'h0020;
      run_count(8, p, f);
      n_checks++; if (p !== 0) $display("FAIL bounce_press_early: got %0d pulses want 0", p); else n_pass++;
      keys = 16'h0000;
      run_count(4, p, f);
      keys = 16'h0020;
      run_count(14, p, f);
      n_checks++; if (f !== 12) $display("FAIL bounce_press_latency: got edge %0d want 12", f); else n_pass++;
      n_checks++; if (p !== 1) $display("FAIL bounce_press_count: got %0d pulses want 1", p); else n_pass++;
   endtask

   task automatic test_sequence;
      logic [3:0] codes [5];
      int p, f;
      codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      do_reset;
      for (int i = 0; i < 5; i++) begin
         keys = 16'd1 << codes[i];
         run_count(16, p, f);
         n_checks++; if (p !== 1 || f !== 12) $display("FAIL seq_pulse_%0d: got %0d pulses first edge %0d want 1 at 12", i, p, f); else n_pass++;
         n_checks++; if (key_code !== codes[i]) $display("FAIL seq_code_%0d: got %0d want %0d", i, key_code, codes[i]); else n_pass++;
         keys = 16'd0;
         run_count(16, p, f);
         n_checks++; if (p !== 0 || key_held !== 1'b0) $display("FAIL seq_release_%0d: got %0d pulses held %b want 0 and 0", i, p, key_held); else n_pass++;
      end
      n_checks++; if (digits !== 16'h2345) $display("FAIL seq_digits: got %h want 2345", digits); else n_pass++;
   endtask

   task automatic test_multi;
      int p, h;
      do_reset;
      keys = 16'h0060;      // keys 5 and 6 together
      p = 0;
      h = 0;
      for (int t = 0; t < 20; t++) begin
         tick;
         if (key_valid) p++;
         if (key_held) h++;
      end
      n_checks++; if (p !== 0) $display("FAIL multi_valid: got %0d pulses want 0", p); else n_pass++;
      n_checks++; if (h !== 0) $display("FAIL multi_held: got %0d held cycles want 0", h); else n_pass++;
      n_checks++; if (digits !== 16'h0000) $display("FAIL multi_digits: got %h want 0000", digits); else n_pass++;
   endtask

   task automatic test_release_bounce;
      int p, f, bad;
      do_reset;
      keys = 16'h0020;
      run_count(12, p, f);
      n_checks++; if (p !== 1 || f !== 12) $display("FAIL rb_accept: got %0d pulses first edge %0d want 1 at 12", p, f); else n_pass++;
      p   = 0;
      bad = 0;
      for (int t = 1; t <= 24; t++) begin
         keys = ((t <= 4) || (t >= 9 && t <= 12)) ? 16'h0020 : 16'h0000;
         tick;
         if (key_valid) p++;
         if (t < 24 && key_held !== 1'b1) bad++;
      end
      n_checks++; if (bad !== 0) $display("FAIL rb_held_through: got %0d cycles low want 0", bad); else n_pass++;
      n_checks++; if (key_held !== 1'b0) $display("FAIL rb_release: got %b want 0 after 3rd empty frame", key_held); else n_pass++;
      n_checks++; if (p !== 0) $display("FAIL rb_repulse: got %0d pulses want 0", p); else n_pass++;
   endtask

   task automatic test_en_drop;
      int p, f;
      do_reset;
      keys = 16'h0020;
      run_count(9, p, f);
      EN = 1'b0;
      #1;
      n_checks++; if (kp_col !== 4'b1111) $display("FAIL en_off_col_now: got %b want 1111", kp_col); else n_pass++;
      tick; tick; tick;
      n_checks++; if (kp_col !== 4'b1111 || key_held !== 1'b0 || key_valid !== 1'b0) $display("FAIL en_off_state: got col %b held %b valid %b want 1111 0 0", kp_col, key_held, key_valid); else n_pass++;
      EN = 1'b1;
      #1;
      n_checks++; if (kp_col !== 4'b1110) $display("FAIL en_on_col: got %b want 1110", kp_col); else n_pass++;
      run_count(14, p, f);
      n_checks++; if (f !== 12 || p !== 1) $display("FAIL en_redebounce: got %0d pulses first edge %0d want 1 at 12", p, f); else n_pass++;
      // Stopping the scan must keep the accepted code and digits.
      EN = 1'b0;
      tick; tick;
      n_checks++; if (key_code !== 4'd5 || digits !== 16'h0005) $display("FAIL en_hold_values: got code %0d digits %h want 5 0005", key_code, digits); else n_pass++;
      n_checks++; if (key_held !== 1'b0) $display("FAIL en_hold_held: got %b want 0", key_held); else n_pass++;
      EN = 1'b1;
   endtask

   task automatic test_rst_mid;
      int p, f;
      do_reset;
      keys = 16'h0020;
      run_count(10, p, f);
      rst = 1'b1;
      tick;
      n_checks++; if (key_valid !== 1'b0 || digits !== 16'h0000 || kp_col !== 4'b1110) $display("FAIL rst_mid_state: got valid %b digits %h col %b want 0 0000 1110", key_valid, digits, kp_col); else n_pass++;
      rst = 1'b0;
      run_count(13, p, f);
      n_checks++; if (f !== 12 || p !== 1) $display("FAIL rst_mid_latency: got %0d pulses first edge %0d want 1 at 12", p, f); else n_pass++;
   endtask

   initial begin
      rst  = 1'b1;
      EN   = 1'b1;
      keys = 16'd0;
      test_reset;
      test_press_latency;
      test_bounce_press;
      test_sequence;
      test_multi;
      test_release_bounce;
      test_en_drop;
      test_rst_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanned 4x4 matrix-keypad reader for the stopwatch front panel: the input-side counterpart of the multiplexed 7-segment driver. It rotates an active-low column strobe and samples the active-low rows, using the same 200 Hz scan clock as the display. Each column result is debounced over whole scan frames. The block reports each accepted keypress once, and shifts the key into a 4-digit register whose 16-bit output feeds the display's `data` input directly.

## Interface
- `DEBOUNCE`, default 3: consecutive identical frames required to accept a press or a release (legal 1..15).
- `clk_200Hz`  in  1  scan clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EN`  in  1  scan enable; 0 = scanning stopped.
- `kp_row`  in  4  keypad rows, active-low, externally pulled up; `kp_row[r]`=0 means a key in row r conducts.
- `kp_col`  out  4  column strobe, active-low one-hot; `4'b1110` drives column 0.
- `key_code`  out  4  code of the last accepted key, computed as 4*r + c.
- `key_valid`  out  1  one-cycle pulse on each accepted press.
- `key_held`  out  1  high while the accepted key is still held (state PRESSED).
- `digits`  out  16  last four accepted codes; newest in [3:0].

## Operation
- Reset values: `kp_col`=4'b1110, scan index 0, `key_code`=0, `key_valid`=0, `key_held`=0, `digits`=0, FSM=IDLE, all counters 0.
- Scan:
  - Each edge samples `kp_row` for the currently driven column c, then rotates `kp_col` left. The sequence is 1110 → 1101 → 1011 → 0111 → 1110.
  - A frame is 4 samples, columns 0..3.
- Frame result:
  - NONE if no row bit is low in any of the 4 samples.
  - SINGLE(code) if exactly one (row, col) is low across the frame.
  - MULTI otherwise; MULTI is treated exactly as NONE.
  - The result is formed combinationally from the accumulated samples plus the column-3 sample, and is evaluated on the column-3 edge.
- FSM, evaluated once per frame-end edge:
  - IDLE:
    - SINGLE(k): candidate ← k, cnt ← 1, go to DEBOUNCE.
    - If DEBOUNCE=1, go directly to PRESSED with the accept actions below.
  - DEBOUNCE:
    - SINGLE(candidate): cnt+1. If cnt reaches DEBOUNCE, go to PRESSED and perform the accept actions.
    - SINGLE(other): candidate ← other, cnt ← 1.
    - NONE or MULTI: go to IDLE, cnt ← 0.
  - Accept actions:
    - `key_code` ← candidate.
    - `key_valid` ← 1 for exactly one cycle.
    - `digits` ← {`digits[11:0]`, candidate}.
  - PRESSED (`key_held`=1):
    - Any frame result other than SINGLE(`key_code`) increments rcnt.
    - SINGLE(`key_code`) clears rcnt.
    - When rcnt reaches DEBOUNCE, go to IDLE and clear rcnt.
    - Re-acceptance of the same or a different key always requires a full debounce from IDLE; there is no auto-repeat.
- EN=0:
  - `kp_col`=4'b1111, scan index 0, FSM forced to IDLE, counters cleared, `key_valid`=0, `key_held`=0.
  - `key_code` and `digits` hold their values.
  - On EN rising, the first edge samples column 0 (`kp_col` is 1110 in the cycle EN is seen high).
- `rst` overrides EN and takes effect mid-frame or mid-debounce with no output pulse.

## Timing
- After `rst` falls, edge 1 samples column 0 and frame n completes at edge 4n.
- Press latency: a key held stable from reset release gives `key_valid` high in the cycle after edge 4·DEBOUNCE. This is edge 12 for the default, about 60 ms at 200 Hz.
- Release latency: `key_held` falls in the cycle after the DEBOUNCE-th consecutive non-matching frame-end edge.
- `key_valid`, `key_code` and `digits` update on the same edge. `key_code` and `digits` are stable for at least 4·DEBOUNCE cycles between updates.
- A press that starts mid-frame after its column was already sampled does not count in that frame.

## Test plan
- Reset, then hold key row1/col1 (`kp_row`=4'b1101 only while `kp_col`=4'b1101) → `key_valid` pulses one cycle after edge 12; `key_code`=5; `digits`=16'h0005; `key_held`=1.
- Hold 5 for 2 frames, release for 1 frame, then hold again → no pulse until 3 full frames after the re-press.
- Press in sequence 1, 2, 3, 4, 5 (col1/row0, col2/row0, col3/row0, col0/row1, col1/row1), each held 4 frames with 4 released frames between → 5 pulses; final `digits`=16'h2345.
- Hold 5 and 6 together → MULTI every frame: no `key_valid`, `key_held`=0.
- Accepted key 5 held, then bounce release (1 empty frame, 1 held frame, 3 empty frames) → `key_held` stays 1 through the bounce, falls after the 3rd consecutive empty frame; no second pulse.
- Drop EN mid-debounce → `kp_col`=4'b1111 and the FSM goes to IDLE. Raise EN with the key still held → column 0 is sampled first and a full 3-frame debounce is needed before the pulse.
